// File: rtl/multi_cycle_ctrl_if.sv
// Control bus between the multi-cycle MIPS main controller and its datapath.
// The controller side (master) reads the latched opcode and the memory ready
// handshake, and drives every datapath strobe and mux select.
interface multi_cycle_ctrl_if #(
  parameter int STATE_W = 4
);

  // Inputs to the controller
  logic [5:0]         OP;
  logic               mem_ready;

  // Strobes and selects driven by the controller
  logic               PCWrite;
  logic               PCWriteCond;
  logic               IorD;
  logic               MemRead;
  logic               MemWrite;
  logic               IRWrite;
  logic               MemtoReg;
  logic               RegDst;
  logic               RegWrite;
  logic               ALUSrcA;
  logic [1:0]         ALUSrcB;
  logic [1:0]         ALUop;
  logic [1:0]         PCSource;
  logic [STATE_W-1:0] state;
  logic               instr_done;
  logic               illegal_op;

  modport master (
    input  OP, mem_ready,
    output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
           MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUop,
           PCSource, state, instr_done, illegal_op
  );

  modport slave (
    output OP, mem_ready,
    input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
           MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUop,
           PCSource, state, instr_done, illegal_op
  );

endinterface

// File: rtl/multi_cycle_ctrl.sv
// Main control FSM of the multi-cycle MIPS datapath. One state per cycle:
// fetch, decode, then an opcode-specific execute/memory/writeback path.
// The state register is the only storage; every output is decoded from it,
// with mem_ready qualifying the fetch and store completion strobes.
module multi_cycle_ctrl #(
  parameter logic [3:0] RESET_STATE = 4'd0,
  parameter int         STATE_W     = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  multi_cycle_ctrl_if.master bus
);

  typedef enum logic [STATE_W-1:0] {
    S_IF  = 4'd0,
    S_ID  = 4'd1,
    S_MA  = 4'd2,
    S_MR  = 4'd3,
    S_MWB = 4'd4,
    S_MWR = 4'd5,
    S_REX = 4'd6,
    S_RWB = 4'd7,
    S_BEQ = 4'd8,
    S_J   = 4'd9,
    S_IEX = 4'd10,
    S_IWB = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_SUB  = 2'b01;
  localparam logic [1:0] ALU_FUNC = 2'b10;

  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       instr_done;
    logic       illegal_op;
  } ctrl_t;

  state_t state_q;
  state_t state_d;
  ctrl_t  ctrl;

  // State register; reset abandons whatever instruction was in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= state_t'(RESET_STATE);
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state selection and Moore output decode, all strobes masked in reset.
  always_comb begin
    state_d = state_q;
    ctrl    = '0;

    case (state_q)
      S_IF: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALU_ADD;
        ctrl.ir_write  = bus.mem_ready;
        ctrl.pc_write  = bus.mem_ready;
        if (bus.mem_ready) begin
          state_d = S_ID;
        end
      end

      S_ID: begin
        // Branch target is precomputed here so BEQ can use ALUOut.
        ctrl.alu_src_b = SRCB_IMMSH;
        ctrl.alu_op    = ALU_ADD;
        case (bus.OP)
          OP_LW, OP_SW: state_d = S_MA;
          OP_RTYPE:     state_d = S_REX;
          OP_BEQ:       state_d = S_BEQ;
          OP_J:         state_d = S_J;
          OP_ADDI:      state_d = S_IEX;
          default: begin
            state_d         = S_IF;
            ctrl.illegal_op = 1'b1;
          end
        endcase
      end

      S_MA: begin
        // OP[3] separates sw (101011) from lw (100011); IR is frozen here.
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALU_ADD;
        state_d        = bus.OP[3] ? S_MWR : S_MR;
      end

      S_MR: begin
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d   = 1'b1;
        if (bus.mem_ready) begin
          state_d = S_MWB;
        end
      end

      S_MWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.instr_done = 1'b1;
        state_d         = S_IF;
      end

      S_MWR: begin
        // The write strobe is held for the whole stall.
        ctrl.mem_write  = 1'b1;
        ctrl.i_or_d     = 1'b1;
        ctrl.instr_done = bus.mem_ready;
        if (bus.mem_ready) begin
          state_d = S_IF;
        end
      end

      S_REX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_B;
        ctrl.alu_op    = ALU_FUNC;
        state_d        = S_RWB;
      end

      S_RWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = 1'b1;
        ctrl.instr_done = 1'b1;
        state_d         = S_IF;
      end

      S_BEQ: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRCB_B;
        ctrl.alu_op        = ALU_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCSRC_ALUOUT;
        ctrl.instr_done    = 1'b1;
        state_d            = S_IF;
      end

      S_J: begin
        ctrl.pc_write   = 1'b1;
        ctrl.pc_source  = PCSRC_JUMP;
        ctrl.instr_done = 1'b1;
        state_d         = S_IF;
      end

      S_IEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALU_ADD;
        state_d        = S_IWB;
      end

      S_IWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.instr_done = 1'b1;
        state_d         = S_IF;
      end

      default: begin
        // Encodings 12-15 are unreachable; recover to fetch quietly.
        state_d = S_IF;
      end
    endcase

    if (!rst_n) begin
      ctrl = '0;
    end
  end

  assign bus.PCWrite     = ctrl.pc_write;
  assign bus.PCWriteCond = ctrl.pc_write_cond;
  assign bus.IorD        = ctrl.i_or_d;
  assign bus.MemRead     = ctrl.mem_read;
  assign bus.MemWrite    = ctrl.mem_write;
  assign bus.IRWrite     = ctrl.ir_write;
  assign bus.MemtoReg    = ctrl.mem_to_reg;
  assign bus.RegDst      = ctrl.reg_dst;
  assign bus.RegWrite    = ctrl.reg_write;
  assign bus.ALUSrcA     = ctrl.alu_src_a;
  assign bus.ALUSrcB     = ctrl.alu_src_b;
  assign bus.ALUop       = ctrl.alu_op;
  assign bus.PCSource    = ctrl.pc_source;
  assign bus.instr_done  = ctrl.instr_done;
  assign bus.illegal_op  = ctrl.illegal_op;
  assign bus.state       = state_q;

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Directed bench for multi_cycle_ctrl: walks each instruction class cycle by
// cycle and compares the state and the full control word against constants.
module tb_multi_cycle_ctrl;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  multi_cycle_ctrl_if bus ();

  multi_cycle_ctrl dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.master)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BAD  = 6'b111111;

  // Control word order:
  // PCWrite PCWriteCond IorD MemRead MemWrite IRWrite MemtoReg RegDst RegWrite
  // ALUSrcA ALUSrcB[1:0] ALUop[1:0] PCSource[1:0] instr_done illegal_op
  localparam logic [17:0] C_ZERO    = 18'b0;
  localparam logic [17:0] C_IF_RDY  = {1'b1,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,2'b01,2'b00,2'b00,1'b0,1'b0};
  localparam logic [17:0] C_IF_WAIT = {1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,2'b00,2'b00,1'b0,1'b0};
  localparam logic [17:0] C_ID      = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b11,2'b00,2'b00,1'b0,1'b0};
  localparam logic [17:0] C_ID_ILL  = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b11,2'b00,2'b00,1'b0,1'b1};
  localparam logic [17:0] C_MA      = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,2'b00,2'b00,1'b0,1'b0};
  localparam logic [17:0] C_MR      = {1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,1'b0,1'b0};
  localparam logic [17:0] C_MWB     = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,2'b00,2'b00,2'b00,1'b1,1'b0};
  localparam logic [17:0] C_MWR_W   = {1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,1'b0,1'b0};
  localparam logic [17:0] C_MWR_R   = {1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,1'b1,1'b0};
  localparam logic [17:0] C_REX     = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b10,2'b00,1'b0,1'b0};
  localparam logic [17:0] C_RWB     = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,2'b00,2'b00,2'b00,1'b1,1'b0};
  localparam logic [17:0] C_BEQ     = {1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b01,2'b01,1'b1,1'b0};
  localparam logic [17:0] C_J       = {1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b10,1'b1,1'b0};
  localparam logic [17:0] C_IEX     = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,2'b00,2'b00,1'b0,1'b0};
  localparam logic [17:0] C_IWB     = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,2'b00,2'b00,2'b00,1'b1,1'b0};

  logic [17:0] ctrl_obs;
  assign ctrl_obs = {bus.PCWrite, bus.PCWriteCond, bus.IorD, bus.MemRead,
                     bus.MemWrite, bus.IRWrite, bus.MemtoReg, bus.RegDst,
                     bus.RegWrite, bus.ALUSrcA, bus.ALUSrcB, bus.ALUop,
                     bus.PCSource, bus.instr_done, bus.illegal_op};

  // Drive one cycle's inputs at the falling edge and let outputs settle.
  task automatic applyStimulus(input logic [5:0] op, input logic ready, input logic rstn);
    @(negedge clk);
    bus.OP        = op;
    bus.mem_ready = ready;
    rst_n         = rstn;
    #1;
  endtask

  // Compare the control word of the current cycle.
  task automatic checkOutput(input string tag, input logic [17:0] exp_ctrl);
    total++;
    assert (ctrl_obs === exp_ctrl)
    else begin
      bad++;
      $error("[TB] FAIL %s ctrl: got %b, expected %b", tag, ctrl_obs, exp_ctrl);
    end
  endtask

  // Compare the debug state of the current cycle.
  task automatic checkState(input string tag, input logic [3:0] exp_state);
    total++;
    assert (bus.state === exp_state)
    else begin
      bad++;
      $error("[TB] FAIL %s state: got %0d, expected %0d", tag, bus.state, exp_state);
    end
  endtask

  initial begin
    total         = 0;
    bad           = 0;
    rst_n         = 1'b0;
    bus.OP        = 6'b0;
    bus.mem_ready = 1'b0;

    // Power-on reset
    applyStimulus(OP_R, 1'b1, 1'b0);
    applyStimulus(OP_R, 1'b1, 1'b0);
    checkState("por", 4'd0);
    checkOutput("por", C_ZERO);

    // Reach MA of a lw, then reset for three cycles from there
    applyStimulus(OP_LW, 1'b1, 1'b1); checkState("pre_if", 4'd0); checkOutput("pre_if", C_IF_RDY);
    applyStimulus(OP_LW, 1'b1, 1'b1); checkState("pre_id", 4'd1); checkOutput("pre_id", C_ID);
    applyStimulus(OP_LW, 1'b1, 1'b1); checkState("pre_ma", 4'd2); checkOutput("pre_ma", C_MA);
    applyStimulus(OP_LW, 1'b1, 1'b0); checkOutput("rst1", C_ZERO);
    applyStimulus(OP_LW, 1'b1, 1'b0); checkState("rst2", 4'd0); checkOutput("rst2", C_ZERO);
    applyStimulus(OP_LW, 1'b1, 1'b0); checkState("rst3", 4'd0); checkOutput("rst3", C_ZERO);

    // lw with memory always ready: 0,1,2,3,4
    applyStimulus(OP_LW, 1'b1, 1'b1); checkState("lw_if", 4'd0); checkOutput("lw_if", C_IF_RDY);
    applyStimulus(OP_LW, 1'b1, 1'b1); checkState("lw_id", 4'd1); checkOutput("lw_id", C_ID);
    applyStimulus(OP_LW, 1'b1, 1'b1); checkState("lw_ma", 4'd2); checkOutput("lw_ma", C_MA);
    applyStimulus(OP_LW, 1'b1, 1'b1); checkState("lw_mr", 4'd3); checkOutput("lw_mr", C_MR);
    applyStimulus(OP_LW, 1'b1, 1'b1); checkState("lw_mwb", 4'd4); checkOutput("lw_mwb", C_MWB);

    // R-type: 0,1,6,7
    applyStimulus(OP_R, 1'b1, 1'b1); checkState("r_if", 4'd0); checkOutput("r_if", C_IF_RDY);
    applyStimulus(OP_R, 1'b1, 1'b1); checkState("r_id", 4'd1); checkOutput("r_id", C_ID);
    applyStimulus(OP_R, 1'b1, 1'b1); checkState("r_rex", 4'd6); checkOutput("r_rex", C_REX);
    applyStimulus(OP_R, 1'b1, 1'b1); checkState("r_rwb", 4'd7); checkOutput("r_rwb", C_RWB);

    // beq: 0,1,8
    applyStimulus(OP_BEQ, 1'b1, 1'b1); checkState("beq_if", 4'd0); checkOutput("beq_if", C_IF_RDY);
    applyStimulus(OP_BEQ, 1'b1, 1'b1); checkState("beq_id", 4'd1); checkOutput("beq_id", C_ID);
    applyStimulus(OP_BEQ, 1'b1, 1'b1); checkState("beq_ex", 4'd8); checkOutput("beq_ex", C_BEQ);

    // sw with two fetch stalls and three store stalls: 9 cycles
    applyStimulus(OP_SW, 1'b0, 1'b1); checkState("sw_if_w1", 4'd0); checkOutput("sw_if_w1", C_IF_WAIT);
    applyStimulus(OP_SW, 1'b0, 1'b1); checkState("sw_if_w2", 4'd0); checkOutput("sw_if_w2", C_IF_WAIT);
    applyStimulus(OP_SW, 1'b1, 1'b1); checkState("sw_if_r", 4'd0); checkOutput("sw_if_r", C_IF_RDY);
    applyStimulus(OP_SW, 1'b1, 1'b1); checkState("sw_id", 4'd1); checkOutput("sw_id", C_ID);
    applyStimulus(OP_SW, 1'b1, 1'b1); checkState("sw_ma", 4'd2); checkOutput("sw_ma", C_MA);
    applyStimulus(OP_SW, 1'b0, 1'b1); checkState("sw_mwr_w1", 4'd5); checkOutput("sw_mwr_w1", C_MWR_W);
    applyStimulus(OP_SW, 1'b0, 1'b1); checkState("sw_mwr_w2", 4'd5); checkOutput("sw_mwr_w2", C_MWR_W);
    applyStimulus(OP_SW, 1'b0, 1'b1); checkState("sw_mwr_w3", 4'd5); checkOutput("sw_mwr_w3", C_MWR_W);
    applyStimulus(OP_SW, 1'b1, 1'b1); checkState("sw_mwr_r", 4'd5); checkOutput("sw_mwr_r", C_MWR_R);

    // addi: 0,1,10,11
    applyStimulus(OP_ADDI, 1'b1, 1'b1); checkState("addi_if", 4'd0); checkOutput("addi_if", C_IF_RDY);
    applyStimulus(OP_ADDI, 1'b1, 1'b1); checkState("addi_id", 4'd1); checkOutput("addi_id", C_ID);
    applyStimulus(OP_ADDI, 1'b1, 1'b1); checkState("addi_iex", 4'd10); checkOutput("addi_iex", C_IEX);
    applyStimulus(OP_ADDI, 1'b1, 1'b1); checkState("addi_iwb", 4'd11); checkOutput("addi_iwb", C_IWB);

    // Illegal opcode: 0,1,0
    applyStimulus(OP_BAD, 1'b1, 1'b1); checkState("ill_if", 4'd0); checkOutput("ill_if", C_IF_RDY);
    applyStimulus(OP_BAD, 1'b1, 1'b1); checkState("ill_id", 4'd1); checkOutput("ill_id", C_ID_ILL);
    applyStimulus(OP_LW, 1'b0, 1'b1); checkState("ill_back", 4'd0); checkOutput("ill_back", C_IF_WAIT);

    // lw stalled in MR, then reset mid-instruction
    applyStimulus(OP_LW, 1'b1, 1'b1); checkState("mid_if", 4'd0); checkOutput("mid_if", C_IF_RDY);
    applyStimulus(OP_LW, 1'b1, 1'b1); checkState("mid_id", 4'd1); checkOutput("mid_id", C_ID);
    applyStimulus(OP_LW, 1'b1, 1'b1); checkState("mid_ma", 4'd2); checkOutput("mid_ma", C_MA);
    applyStimulus(OP_LW, 1'b0, 1'b1); checkState("mid_mr", 4'd3); checkOutput("mid_mr", C_MR);
    applyStimulus(OP_LW, 1'b1, 1'b0); checkState("mid_rst", 4'd3); checkOutput("mid_rst", C_ZERO);

    // j after the abandoned lw: 0,1,9 then back to fetch
    applyStimulus(OP_J, 1'b1, 1'b1); checkState("j_if", 4'd0); checkOutput("j_if", C_IF_RDY);
    applyStimulus(OP_J, 1'b1, 1'b1); checkState("j_id", 4'd1); checkOutput("j_id", C_ID);
    applyStimulus(OP_J, 1'b1, 1'b1); checkState("j_ex", 4'd9); checkOutput("j_ex", C_J);
    applyStimulus(OP_J, 1'b0, 1'b1); checkState("j_next", 4'd0); checkOutput("j_next", C_IF_WAIT);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multi_cycle_ctrl.md
Name: multi_cycle_ctrl

Overview:
Main control FSM for the multi-cycle MIPS datapath. Decodes the latched opcode and sequences the fetch, decode, execute, memory and writeback steps, one state per cycle. It drives the 2-bit ALUop consumed by the ALU control unit: 00 = add, 01 = sub, 10 = use FUNC. It stalls on a shared-memory ready handshake.

Parameters:
RESET_STATE, 4'd0, state entered on reset (IF); must stay 0.
STATE_W, 4, state register width.

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  synchronous active-low reset
OP  in  6  opcode field from instruction register (IR[31:26])
mem_ready  in  1  memory completes the current read/write this cycle
PCWrite  out  1  unconditional PC load
PCWriteCond  out  1  PC load qualified by ALU zero (beq)
IorD  out  1  memory address select: 0 = PC, 1 = ALUOut
MemRead  out  1  memory read strobe
MemWrite  out  1  memory write strobe
IRWrite  out  1  instruction register load
MemtoReg  out  1  register write data: 0 = ALUOut, 1 = MDR
RegDst  out  1  destination register: 0 = rt, 1 = rd
RegWrite  out  1  register file write enable
ALUSrcA  out  1  ALU A input: 0 = PC, 1 = A register
ALUSrcB  out  2  ALU B input: 00 = B, 01 = 4, 10 = sign-extended imm, 11 = sign-extended imm << 2
ALUop  out  2  to ALU control: 00 add, 01 sub, 10 R-type
PCSource  out  2  next PC: 00 = ALU result, 01 = ALUOut, 10 = jump target
state  out  4  current state, for debug
instr_done  out  1  one-cycle pulse in the final cycle of each instruction
illegal_op  out  1  one-cycle pulse when ID decodes an unsupported opcode

Behaviour:
- Only sequential element is the 4-bit state register. All outputs are Moore decodes of state. Exceptions: IRWrite, PCWrite in IF; MemWrite's completion; and instr_done, which are also gated by mem_ready where noted.
- Reset: rst_n=0 sampled at a clk edge puts state at IF (0). While rst_n=0, every strobe output is forced to 0: PCWrite, PCWriteCond, MemRead, MemWrite, IRWrite, RegWrite, instr_done, illegal_op. Mux selects and ALUop are 0 during reset. Reset mid-instruction abandons it; no partial writeback occurs after the edge.
- Any output not listed for a state is 0.
- State encodings, outputs and transitions:
  - 0 IF: MemRead=1, ALUSrcB=01, ALUop=00. IRWrite=PCWrite=mem_ready. mem_ready=1 -> ID, else stay in IF.
  - 1 ID: ALUSrcB=11, ALUop=00 (branch target into ALUOut). Next state by OP:
    - 100011 (lw) or 101011 (sw) -> MA
    - 000000 -> REX
    - 000100 -> BEQ
    - 000010 -> J
    - 001000 (addi) -> IEX
    - any other opcode -> IF with illegal_op=1
  - 2 MA: ALUSrcA=1, ALUSrcB=10, ALUop=00. lw -> MR, sw -> MWR. Decide on OP[3], which is stable because IR is not rewritten outside IF.
  - 3 MR: MemRead=1, IorD=1. mem_ready -> MWB, else stay.
  - 4 MWB: RegWrite=1, MemtoReg=1, RegDst=0, instr_done=1. -> IF.
  - 5 MWR: MemWrite=1, IorD=1, instr_done=mem_ready. mem_ready -> IF, else stay. MemWrite stays asserted for the whole stall.
  - 6 REX: ALUSrcA=1, ALUSrcB=00, ALUop=10. -> RWB.
  - 7 RWB: RegWrite=1, RegDst=1, MemtoReg=0, instr_done=1. -> IF.
  - 8 BEQ: ALUSrcA=1, ALUSrcB=00, ALUop=01, PCWriteCond=1, PCSource=01, instr_done=1. -> IF.
  - 9 J: PCWrite=1, PCSource=10, instr_done=1. -> IF.
  - 10 IEX: ALUSrcA=1, ALUSrcB=10, ALUop=00. -> IWB.
  - 11 IWB: RegWrite=1, RegDst=0, MemtoReg=0, instr_done=1. -> IF.
  - 12-15 are unreachable. If entered, all outputs are 0 and the next state is IF.
- CPI with mem_ready tied high: lw 5, sw 4, R 4, addi 4, beq 3, j 3. Each cycle mem_ready is low in IF/MR/MWR adds one cycle.
- Each of MemRead/MemWrite and RegWrite/MemWrite is mutually exclusive in every state. ALUop=11 is never produced.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles from an arbitrary state, then release -> all strobes 0 during reset; state=0 on the first cycle after release; MemRead=1 in that cycle.
- lw, mem_ready=1: OP=100011 -> states 0,1,2,3,4. RegWrite=1 and MemtoReg=1 only in cycle 5. instr_done pulses once.
- R-type then beq, mem_ready=1: OP=000000 -> 0,1,6,7 with ALUop=10 in state 6. Then OP=000100 -> 0,1,8 with ALUop=01, PCWriteCond=1, PCSource=01.
- Memory stall: OP=101011, mem_ready=0 for 2 cycles in IF and 3 cycles in MWR -> IRWrite/PCWrite only in the ready cycle. MemWrite is high for 4 consecutive cycles. Total 9 cycles.
- Illegal opcode: OP=111111 -> 0,1,0. illegal_op pulses in ID; no RegWrite, MemWrite or PCWrite beyond the fetch.
- Reset mid-instruction: assert rst_n=0 while in state 3 (MR) -> state=0 next cycle; RegWrite never asserted; j (OP=000010) afterwards completes in 3 cycles with PCSource=10.
